// File: rtl/uart_fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a uart_fifo.
// A grant is held until end of packet, the burst limit, or the owner idle watchdog.
module uart_fifo_wr_arbiter #(
    parameter int DATA_SIZE    = 8,
    parameter int NUM_REQ      = 2,
    parameter int ID_WIDTH     = $clog2(NUM_REQ),
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_wr,
    output logic [DATA_SIZE-1:0]           fifo_w_data,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] rr_q, rr_d;
    logic [7:0]          burst_q, burst_d;
    logic [7:0]          idle_q, idle_d;

    logic [DATA_SIZE-1:0] slice [NUM_REQ];
    logic                 found;
    logic [ID_WIDTH-1:0]  winner;
    logic [ID_WIDTH-1:0]  next_ptr;
    logic                 own_valid;
    logic                 own_last;
    logic                 xfer;
    logic                 release_lock;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = req_data[g*DATA_SIZE +: DATA_SIZE];
    end

    // Search starts at rr_q and wraps, so the previous owner is looked at last.
    always_comb begin : rr_search
        int unsigned         scan;
        logic [ID_WIDTH-1:0] cand;
        found  = 1'b0;
        winner = rr_q;
        scan   = 0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan = 32'(rr_q) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            cand = ID_WIDTH'(scan);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign next_ptr  = (grant_q == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
    assign own_valid = req_valid[grant_q];
    assign own_last  = req_last[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        burst_d      = burst_q;
        idle_d       = idle_q;
        req_ready    = '0;
        fifo_wr      = 1'b0;
        fifo_w_data  = '0;
        xfer         = 1'b0;
        release_lock = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCK;
                    grant_d = winner;
                    burst_d = '0;
                    idle_d  = '0;
                end
            end
            LOCK: begin
                req_ready[grant_q] = ~fifo_full;
                xfer               = own_valid & ~fifo_full;
                fifo_wr            = xfer;
                fifo_w_data        = slice[grant_q];
                // Stalls on fifo_full with valid high leave idle_q untouched.
                if (xfer) begin
                    burst_d = burst_q + 8'd1;
                    idle_d  = '0;
                end else if (!own_valid) begin
                    idle_d = idle_q + 8'd1;
                end
                release_lock = (xfer && (own_last || burst_q == 8'(MAX_BURST-1)))
                            || (!own_valid && idle_q == 8'(IDLE_TIMEOUT-1));
                if (release_lock) begin
                    state_d = IDLE;
                    rr_d    = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == LOCK);

endmodule

// File: tb/tb_uart_fifo_wr_arbiter.sv
// Directed vector bench for uart_fifo_wr_arbiter (2 requesters, MAX_BURST=4, IDLE_TIMEOUT=16).
module tb_uart_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [7:0]  fifo_w_data;
    logic        grant_id;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    uart_fifo_wr_arbiter #(
        .DATA_SIZE   (8),
        .NUM_REQ     (2),
        .MAX_BURST   (4),
        .IDLE_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_w_data(fifo_w_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [1:0]  valid;
        logic [15:0] data;
        logic [1:0]  last;
        logic        full;
        logic [1:0]  ready;
        logic        wr;
        logic [7:0]  wdata;
        logic        busy;
        logic        gid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [1:0] v, logic [15:0] d, logic [1:0] l,
                                logic f, logic [1:0] rdy, logic wr, logic [7:0] wd,
                                logic b, logic g);
        vec_t r;
        r.rst = rst; r.valid = v; r.data = d; r.last = l; r.full = f;
        r.ready = rdy; r.wr = wr; r.wdata = wd; r.busy = b; r.gid = g;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic wr_seen;

        #2 reset_n = 1'b0;

        // Reset state and single packet
        vecs.push_back(mk(1, 2'b00, 16'h0000, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b01, 16'h006C, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b01, 16'h006C, 2'b00, 0, 2'b01, 1, 8'h6C, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h00AF, 2'b00, 0, 2'b01, 1, 8'hAF, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h0064, 2'b01, 0, 2'b01, 1, 8'h64, 1, 0));
        vecs.push_back(mk(0, 2'b00, 16'h0000, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        // Contention after reset, then rotation back to req0
        vecs.push_back(mk(1, 2'b00, 16'h0000, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b11, 16'hB0A0, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b11, 16'hB0A0, 2'b00, 0, 2'b01, 1, 8'hA0, 1, 0));
        vecs.push_back(mk(0, 2'b11, 16'hB0A1, 2'b01, 0, 2'b01, 1, 8'hA1, 1, 0));
        vecs.push_back(mk(0, 2'b10, 16'hB000, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b10, 16'hB000, 2'b00, 0, 2'b10, 1, 8'hB0, 1, 1));
        vecs.push_back(mk(0, 2'b10, 16'hB100, 2'b10, 0, 2'b10, 1, 8'hB1, 1, 1));
        vecs.push_back(mk(0, 2'b11, 16'hC1C0, 2'b00, 0, 2'b00, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 2'b11, 16'hC1C0, 2'b01, 0, 2'b01, 1, 8'hC0, 1, 0));
        vecs.push_back(mk(0, 2'b00, 16'h0000, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        // Backpressure mid-packet and full coinciding with last
        vecs.push_back(mk(0, 2'b01, 16'h0011, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b01, 16'h0011, 2'b00, 0, 2'b01, 1, 8'h11, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h0022, 2'b00, 1, 2'b00, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h0022, 2'b00, 1, 2'b00, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h0022, 2'b00, 0, 2'b01, 1, 8'h22, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h0033, 2'b00, 0, 2'b01, 1, 8'h33, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h0044, 2'b01, 1, 2'b00, 0, 8'h00, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h0044, 2'b01, 0, 2'b01, 1, 8'h44, 1, 0));
        vecs.push_back(mk(0, 2'b00, 16'h0000, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        // Burst limit: req0 six words split 4 + 2 around req1's packet
        vecs.push_back(mk(1, 2'b00, 16'h0000, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b11, 16'hF0E0, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b11, 16'hF0E0, 2'b00, 0, 2'b01, 1, 8'hE0, 1, 0));
        vecs.push_back(mk(0, 2'b11, 16'hF0E1, 2'b00, 0, 2'b01, 1, 8'hE1, 1, 0));
        vecs.push_back(mk(0, 2'b11, 16'hF0E2, 2'b00, 0, 2'b01, 1, 8'hE2, 1, 0));
        vecs.push_back(mk(0, 2'b11, 16'hF0E3, 2'b00, 0, 2'b01, 1, 8'hE3, 1, 0));
        vecs.push_back(mk(0, 2'b11, 16'hF0E4, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 2'b11, 16'hF0E4, 2'b00, 0, 2'b10, 1, 8'hF0, 1, 1));
        vecs.push_back(mk(0, 2'b11, 16'hF1E4, 2'b10, 0, 2'b10, 1, 8'hF1, 1, 1));
        vecs.push_back(mk(0, 2'b01, 16'h00E4, 2'b00, 0, 2'b00, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 2'b01, 16'h00E4, 2'b00, 0, 2'b01, 1, 8'hE4, 1, 0));
        vecs.push_back(mk(0, 2'b01, 16'h00E5, 2'b01, 0, 2'b01, 1, 8'hE5, 1, 0));
        vecs.push_back(mk(0, 2'b00, 16'h0000, 2'b00, 0, 2'b00, 0, 8'h00, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n   = ~vecs[i].rst;
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            req_last  = vecs[i].last;
            fifo_full = vecs[i].full;
            #1;
            check("req_ready", i, 32'(req_ready), 32'(vecs[i].ready));
            check("fifo_wr",   i, 32'(fifo_wr),   32'(vecs[i].wr));
            check("busy",      i, 32'(busy),      32'(vecs[i].busy));
            check("grant_id",  i, 32'(grant_id),  32'(vecs[i].gid));
            if (vecs[i].wr || vecs[i].rst) begin
                check("fifo_w_data", i, 32'(fifo_w_data), 32'(vecs[i].wdata));
            end
        end

        // Watchdog: req0 granted then goes quiet while req1 waits
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; req_data = 16'h0000; req_last = 2'b00;
        #1 check("wd_idle_busy", 0, 32'(busy), 32'd0);
        @(negedge clk);
        req_valid = 2'b10; req_data = 16'h5A00; req_last = 2'b10;
        cnt = 0;
        wr_seen = 1'b0;
        #1;
        while (busy && cnt < 40) begin
            cnt++;
            if (fifo_wr) wr_seen = 1'b1;
            @(negedge clk);
            #1;
        end
        check("wd_lock_cycles", 0, 32'(cnt), 32'd16);
        check("wd_no_write", 0, 32'(wr_seen), 32'd0);
        check("wd_gap_ready", 0, 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("wd_next_busy", 0, 32'(busy), 32'd1);
        check("wd_next_gid", 0, 32'(grant_id), 32'd1);
        check("wd_next_wr", 0, 32'(fifo_wr), 32'd1);
        check("wd_next_data", 0, 32'(fifo_w_data), 32'h5A);
        @(negedge clk);
        req_valid = 2'b00; req_last = 2'b00;

        // Async reset mid-packet after rr_ptr has moved to 1
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; req_data = 16'h0030; req_last = 2'b01;
        @(negedge clk);
        #1 check("rst_pkt0_wr", 0, 32'(fifo_wr), 32'd1);
        @(negedge clk);
        req_valid = 2'b01; req_data = 16'h0031; req_last = 2'b00;
        @(negedge clk);
        #1 check("rst_w1_wr", 0, 32'(fifo_w_data), 32'h31);
        @(negedge clk);
        req_data = 16'h0032;
        #1 check("rst_w2_wr", 0, 32'(fifo_wr), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_async_wr", 0, 32'(fifo_wr), 32'd0);
        check("rst_async_busy", 0, 32'(busy), 32'd0);
        check("rst_async_ready", 0, 32'(req_ready), 32'd0);
        check("rst_async_data", 0, 32'(fifo_w_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        req_valid = 2'b11; req_data = 16'h9080; req_last = 2'b00;
        #1 check("rst_rearb_idle", 0, 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("rst_rearb_gid", 0, 32'(grant_id), 32'd0);
        check("rst_rearb_data", 0, 32'(fifo_w_data), 32'h80);
        @(negedge clk);
        req_valid = 2'b00;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_fifo_wr_arbiter.md
Name: uart_fifo_wr_arbiter

Overview:
Shares the single write port of one uart_fifo instance between NUM_REQ independent producers, for example a CPU register path and a DMA path. Arbitration is round-robin with packet lock: once a requester is granted, it owns the FIFO until its last word. A burst limit and a stall watchdog force release so that no requester can starve the others. The block sits directly in front of uart_fifo's w_data/wr/full pins.

Parameters:
DATA_SIZE, 8, width of one FIFO word
NUM_REQ, 2, number of requesters (2..8)
ID_WIDTH, $clog2(NUM_REQ), width of grant_id
MAX_BURST, 16, maximum words per grant before forced release (1..255)
IDLE_TIMEOUT, 16, consecutive owner-idle cycles before forced release (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_SIZE  per-requester word; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE]
req_last  in  NUM_REQ  qualifies req_data[i] as the final word of its packet
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
fifo_full  in  1  from uart_fifo full
fifo_wr  out  1  to uart_fifo wr
fifo_w_data  out  DATA_SIZE  to uart_fifo w_data
grant_id  out  ID_WIDTH  current or last owner index (registered)
busy  out  1  high while a grant is held (state LOCK)

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, burst_cnt=0, idle_cnt=0. req_ready, fifo_wr and fifo_w_data are all 0 while reset_n=0.
- FSM states: IDLE, LOCK.
- IDLE:
  - Search req_valid round-robin starting at index rr_ptr, wrapping at NUM_REQ-1 back to 0.
  - First valid index found is the winner. Next edge: grant_id<=winner, state<=LOCK, counters cleared.
  - With no valid requests, stay in IDLE.
  - All req_ready=0 and fifo_wr=0 in IDLE.
  - Arbitration latency is exactly 1 cycle from request to first possible accept.
- LOCK, combinational outputs:
  - req_ready[grant_id] = ~fifo_full; all other ready bits are 0.
  - xfer = req_valid[grant_id] & ~fifo_full.
  - fifo_wr = xfer.
  - fifo_w_data = slice of req_data for grant_id. Don't-care when fifo_wr=0, but driven from the slice, not latched.
- LOCK, sequential:
  - On xfer: burst_cnt++ and idle_cnt<=0.
  - When req_valid[grant_id]=0: idle_cnt++. Cycles stalled by fifo_full while valid is high do not count toward idle_cnt.
- LOCK, release to IDLE with rr_ptr<=(grant_id+1) mod NUM_REQ when any of the following holds:
  - xfer & req_last[grant_id] (normal end of packet);
  - xfer & burst_cnt==MAX_BURST-1 (burst limit reached); the requester's remaining words are re-arbitrated later;
  - idle_cnt==IDLE_TIMEOUT-1 & ~req_valid[grant_id] (stall watchdog).
- Released owner: lowest priority in the next arbitration, so there are no back-to-back grants while another requester is valid.
- Minimum gap between packets: 1 cycle in IDLE between release and the next grant. Throughput within a packet is 1 word/cycle while the FIFO is not full.
- fifo_full rising in the same cycle as last: no transfer, stay in LOCK, retry when full drops.
- Word integrity: a word is never written to the FIFO while fifo_full=1, and never written twice.
- Reset asserted mid-burst: outputs drop immediately (asynchronously) and the FSM returns to IDLE. The partial packet is not resumed; requesters must resend.
- Non-owner requesters: req_valid/req_data may change freely. The owner must hold req_data and req_last stable while valid & ~ready.

Test Plan:
1. Single packet, NUM_REQ=2: req0 sends 0x6C, 0xAF, 0x64 with last on 0x64, fifo_full=0. Expect busy=1 one cycle after req_valid, fifo_wr high 3 consecutive cycles carrying 0x6C/0xAF/0x64, then IDLE and busy=0. A downstream FIFO read returns the same order.
2. Contention after reset: req0 and req1 each present a 2-word packet on the same edge. Expect req0 granted first (rr_ptr=0), then a 1-cycle IDLE gap, then req1 (grant_id=1). A subsequent simultaneous request grants req0 again.
3. Backpressure: fifo_full held high for 2 cycles after the first word of a 4-word packet. Expect req_ready=0 and fifo_wr=0 for those 2 cycles, no duplicate writes, and exactly 4 fifo_wr pulses in total.
4. Burst limit, MAX_BURST=4: req0 sends 6 words, req1 is waiting. Expect 4 writes from req0, release, req1's packet, then req0's remaining 2 words.
5. Watchdog, IDLE_TIMEOUT=16: req0 is granted and then drops req_valid. Expect release after 16 cycles with busy falling, and a waiting req1 granted on the following cycle.
6. Reset mid-packet: reset_n pulled low during the 2nd of 3 words. Expect fifo_wr=0 and busy=0 without waiting for a clock edge; after release, a fresh arbitration starts at rr_ptr=0.
